mbtrain_sb_arbiter: RTL
=======================

MBTRAIN_SB_ARBITER -- requirements
Module: mbtrain_sb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the cycles allowed for sideband busy to rise after launch.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_en, input, 1 bit: enable from the MBTRAIN controller; low forces the block idle.
REQ-005 SHALL have ports i_tx_valid / i_tx_msg, inputs, 1 and 4 bits: the TX-side requester's level request and its message.
REQ-006 SHALL have ports i_rx_valid / i_rx_msg, inputs, 1 and 4 bits: the RX-side requester's level request and its message.
REQ-007 SHALL have port i_sb_busy, input, 1 bit: sideband serializer busy.
REQ-008 SHALL have ports o_sb_valid / o_sb_msg / o_sb_src, outputs, 1, 4 and 1 bits: launched message; o_sb_src is 0 for TX and 1 for RX.
REQ-009 SHALL have ports o_tx_done / o_rx_done, outputs, 1 bit each: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port o_timeout, output, 1 bit: sticky launch-timeout flag.

Function
REQ-011 SHALL implement the FSM states IDLE, LAUNCH, WAIT_DONE and RELEASE.
REQ-012 IDLE: with i_en=1 and at least one valid request, SHALL register the grant (source, message) and move to LAUNCH on the next edge.
- Otherwise SHALL stay in IDLE.
REQ-013 Arbitration:
- Single requester: SHALL grant it.
- Both requesting: SHALL grant the source not granted last.
- Last-grant pointer: reset value RX, so TX wins the first tie.
REQ-014 Granted message 4'b0000: SHALL be a no-op.
- Next state RELEASE, o_sb_valid never asserted.
- Done pulse still issued.
REQ-015 LAUNCH:
- SHALL hold o_sb_valid=1 with o_sb_msg and o_sb_src stable.
- When i_sb_busy is sampled 1, SHALL move to WAIT_DONE and drop o_sb_valid.
REQ-016 WAIT_DONE: when i_sb_busy is sampled 0, SHALL move to RELEASE.
REQ-017 RELEASE:
- Lasts exactly one cycle.
- The granted source's done output is 1 during this cycle.
- SHALL update the last-grant pointer, then return to IDLE.
- No grant is made in RELEASE.
REQ-018 Requesters SHALL hold valid and message until their done pulse.
- A request still valid in the IDLE cycle after RELEASE is a new request.
REQ-019 The latch-to-sideband launch latency SHALL be 1 cycle: request sampled in IDLE at cycle t gives o_sb_valid=1 at t+1.
REQ-020 A requester dropping valid after grant SHALL NOT abort the transaction.
REQ-021 i_en=0 in any state SHALL return the FSM to IDLE on the next edge.
- o_sb_valid and the done outputs go to 0.
- No done pulse is issued.
- o_timeout is cleared.
- The pointer is unchanged.
REQ-022 i_sb_busy already 1 on entry to LAUNCH SHALL count as the rise, giving WAIT_DONE on the next edge.

Reset
REQ-023 rst=1 SHALL set, at the next clk edge:
- FSM to IDLE, pointer to RX, timeout counter to 0.
- o_sb_valid=0, o_sb_msg=0, o_sb_src=0, o_tx_done=0, o_rx_done=0, o_timeout=0.
REQ-024 rst mid-transaction SHALL abandon the grant without a done pulse.

Configuration
REQ-025 With macro MBTRAIN_SB_ARB_TIMEOUT_EN defined:
- A counter SHALL count the cycles spent in LAUNCH.
- On reaching TIMEOUT_CYCLES it SHALL set o_timeout=1 (sticky until rst or i_en=0) and go to RELEASE.
- A done pulse is still issued.
REQ-026 Without the macro:
- The counter SHALL be absent.
- o_timeout is tied 0.
- LAUNCH waits indefinitely.

Structure
REQ-027 SHALL place the FSM state encoding and the sideband message codes (START_REQ 4'b0001 through EXIT_TO_PHYRETRAIN_RESP 4'b1100) in shared package mbtrain_pkg.
REQ-028 SHALL place the 2-way round-robin pick logic in sub-module mbtrain_rr_arb2 (inputs: two requests, pointer; output: grant).

Verification
REQ-029 TX-only, i_tx_msg=4'b0001, busy high for 3 cycles after launch:
- o_sb_valid=1 one cycle after the request, with o_sb_src=0.
- o_tx_done pulses once, one cycle after busy falls.
REQ-030 TX and RX both valid from reset:
- TX is granted first, then RX (message 4'b0010).
- A third tie goes to TX.
REQ-031 RX message 4'b0000:
- No o_sb_valid.
- o_rx_done pulses 2 cycles after the request.
REQ-032 With the macro defined and TIMEOUT_CYCLES=4, busy held 0:
- o_timeout=1 after 4 LAUNCH cycles.
- Done pulse issued.
- Flag clears on i_en=0.
REQ-033 i_en drops, or rst is asserted, during WAIT_DONE:
- Next cycle is IDLE, all outputs 0.
- No done pulse.
- A subsequent tie grants per the unchanged pointer.

Source files
------------

// File: rtl/mbtrain_pkg.sv
// MBTRAIN sideband arbiter shared definitions:
// FSM state encoding, sideband message codes and grant bundle.
package mbtrain_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_RELEASE   = 2'd3;

  localparam logic SRC_TX = 1'b0;
  localparam logic SRC_RX = 1'b1;

  localparam logic [3:0] MSG_NOP                    = 4'b0000;
  localparam logic [3:0] START_REQ                  = 4'b0001;
  localparam logic [3:0] START_RESP                 = 4'b0010;
  localparam logic [3:0] END_REQ                    = 4'b0011;
  localparam logic [3:0] END_RESP                   = 4'b0100;
  localparam logic [3:0] RESULT_REQ                 = 4'b0101;
  localparam logic [3:0] RESULT_RESP                = 4'b0110;
  localparam logic [3:0] EXIT_TO_REPAIR_REQ         = 4'b0111;
  localparam logic [3:0] EXIT_TO_REPAIR_RESP        = 4'b1000;
  localparam logic [3:0] EXIT_TO_SPEEDDEGRADE_REQ   = 4'b1001;
  localparam logic [3:0] EXIT_TO_SPEEDDEGRADE_RESP  = 4'b1010;
  localparam logic [3:0] EXIT_TO_PHYRETRAIN_REQ     = 4'b1011;
  localparam logic [3:0] EXIT_TO_PHYRETRAIN_RESP    = 4'b1100;

  typedef struct packed {
    logic       src;
    logic [3:0] msg;
  } sb_grant_t;

endpackage

// File: rtl/mbtrain_rr_arb2.sv
// Two-way round-robin pick between TX and RX requesters.
// ptr holds the last granted source; a tie goes to the other one.
module mbtrain_rr_arb2
  import mbtrain_pkg::*;
(
  input  logic req_tx,
  input  logic req_rx,
  input  logic ptr,
  output logic gnt
);

  always_comb begin
    gnt = SRC_TX;
    if (req_tx && req_rx)
      gnt = ~ptr;
    else if (req_rx)
      gnt = SRC_RX;
  end

endmodule

// File: rtl/mbtrain_sb_arbiter.sv
// MBTRAIN sideband arbiter: round-robin launch of TX/RX messages.
// Optional launch timeout enabled by MBTRAIN_SB_ARB_TIMEOUT_EN.
module mbtrain_sb_arbiter
  import mbtrain_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_tx_valid,
  input  logic [3:0] i_tx_msg,
  input  logic       i_rx_valid,
  input  logic [3:0] i_rx_msg,
  input  logic       i_sb_busy,
  output logic       o_sb_valid,
  output logic [3:0] o_sb_msg,
  output logic       o_sb_src,
  output logic       o_tx_done,
  output logic       o_rx_done,
  output logic       o_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0] state_q;
  logic [1:0] state_d;
  sb_grant_t  gnt_q;
  logic       ptr_q;
  logic       pick;
  logic       any_req;
  logic       is_nop;
  logic       launch_live;
  logic       release_ok;
  logic       to_hit;

  mbtrain_rr_arb2 u_rr (
    .req_tx (i_tx_valid),
    .req_rx (i_rx_valid),
    .ptr    (ptr_q),
    .gnt    (pick)
  );

  assign any_req     = i_tx_valid || i_rx_valid;
  assign is_nop      = (gnt_q.msg == MSG_NOP);
  assign launch_live = (state_q == ST_LAUNCH) && !is_nop;
  assign release_ok  = (state_q == ST_RELEASE) && i_en;

`ifdef MBTRAIN_SB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  assign to_hit = launch_live && !i_sb_busy &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (to_hit) begin
      cnt_q     <= '0;
      timeout_q <= 1'b1;
    end else if (launch_live && !i_sb_busy) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req)
          state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (is_nop)
          state_d = ST_RELEASE;
        else if (i_sb_busy)
          state_d = ST_WAIT_DONE;
        else if (to_hit)
          state_d = ST_RELEASE;
      end
      ST_WAIT_DONE: begin
        if (!i_sb_busy)
          state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (!i_en)
      state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= SRC_RX;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && i_en && any_req) begin
        gnt_q.src <= pick;
        gnt_q.msg <= (pick == SRC_RX) ? i_rx_msg : i_tx_msg;
      end
      if (release_ok)
        ptr_q <= gnt_q.src;
    end
  end

  // Message and source are only driven while a launch is visible.
  assign o_sb_valid = launch_live;
  assign o_sb_msg   = launch_live ? gnt_q.msg : 4'b0000;
  assign o_sb_src   = launch_live ? gnt_q.src : 1'b0;
  assign o_tx_done  = release_ok && (gnt_q.src == SRC_TX);
  assign o_rx_done  = release_ok && (gnt_q.src == SRC_RX);

endmodule
